// File: rtl/rf_dump_engine.sv
// Register-file readout engine: walks every architectural register through a
// dedicated RF read port and streams (index, value) pairs over valid/ready.
module rf_dump_engine #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_REGS  = 32,
    parameter int END_COUNT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              freeze_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_idx_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = (END_COUNT < 2) ? 1 : $clog2(END_COUNT + 1);

    typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              armed;
    logic [ADDR_W-1:0] idx;
    logic              auto_trig;
    logic              trig;
    logic              accept;
    logic              last;

    // The automatic trigger only ever fires once per reset: armed is
    // cleared by whichever trigger source starts the dump.
    assign auto_trig = armed && (END_COUNT != 0) && (cnt == CNT_W'(END_COUNT));
    assign trig      = (state == IDLE) && (start_i || auto_trig);
    assign accept    = (state == SEND) && out_valid_o && out_ready_i;
    assign last      = (idx == ADDR_W'(NUM_REGS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        freeze_o  = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        rf_addr_o = '0;
        case (state)
            IDLE: begin
                if (trig) state_nxt = REQ;
            end
            REQ: begin
                freeze_o  = 1'b1;
                busy_o    = 1'b1;
                rf_addr_o = idx;
                state_nxt = SEND;
            end
            SEND: begin
                freeze_o = 1'b1;
                busy_o   = 1'b1;
                if (accept) state_nxt = last ? DONE : REQ;
            end
            DONE: begin
                freeze_o  = 1'b1;
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            armed       <= 1'b1;
            idx         <= '0;
            out_valid_o <= 1'b0;
            out_idx_o   <= '0;
            out_data_o  <= '0;
        end else begin
            if (cnt < CNT_W'(END_COUNT)) cnt <= cnt + 1'b1;
            if (trig) begin
                idx   <= '0;
                armed <= 1'b0;
            end
            // RF data is sampled only here; later RF writes cannot disturb the held word.
            if (state == REQ) begin
                out_data_o  <= rf_data_i;
                out_idx_o   <= idx;
                out_valid_o <= 1'b1;
            end
            if (accept) begin
                out_valid_o <= 1'b0;
                if (!last) idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/rf_dump_engine.md
# rf_dump_engine

Synthesizable register-file readout engine for the pipelined CPU. It sequentially reads all architectural registers through a dedicated RF read port and streams each (index, value) pair out over a valid/ready interface. Dumps start either from a manual start pulse or automatically after a programmed cycle count. It sits beside the register file and feeds a debug sink, such as a UART bridge or a bench monitor, so end-of-run register checks no longer need hierarchical peeks.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- NUM_REGS, 32, registers dumped (indices 0..NUM_REGS-1)
- END_COUNT, 15, cycles after reset at which the automatic dump fires; 0 disables the automatic trigger

- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  manual dump request; sampled only in IDLE
- rf_addr_o  out  ADDR_W  read address to the RF debug port
- rf_data_i  in  DATA_W  combinational RF read data for rf_addr_o
- freeze_o  out  1  CPU stall request; high while a dump is in progress
- out_valid_o  out  1  stream word valid
- out_ready_i  in  1  sink ready
- out_idx_o  out  ADDR_W  register index of the current word
- out_data_o  out  DATA_W  register value of the current word
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse after the last word is accepted

## Operation
- Reset values: out_valid_o, out_data_o, out_idx_o, rf_addr_o, freeze_o, busy_o and done_o are all 0. The cycle counter is 0, the armed flag is 1 and the state is IDLE.
- Cycle counter: increments on each edge while below END_COUNT, then saturates.
- Automatic trigger condition: armed, END_COUNT≠0 and count==END_COUNT.
- Trigger: in IDLE, start_i or the automatic trigger condition moves the state to REQ on the next edge.
  - idx is set to 0.
  - armed is cleared, whichever source fired, so the automatic dump fires at most once per reset.
  - If both sources are active in the same cycle, exactly one dump runs.
- States:
  - IDLE: waits for a trigger.
  - REQ: drives rf_addr_o=idx. On the next edge it captures rf_data_i into out_data_o, sets out_idx_o=idx, sets out_valid_o=1 and moves to SEND.
  - SEND: holds out_valid_o, out_idx_o and out_data_o stable until out_valid_o&&out_ready_i.
    - On acceptance with idx==NUM_REGS-1: out_valid_o is cleared and the state moves to DONE.
    - On acceptance otherwise: out_valid_o is cleared, idx increments and the state moves to REQ.
  - DONE: done_o=1 for exactly this cycle, then IDLE.
- freeze_o=1 in REQ, SEND and DONE. busy_o has the same value as freeze_o.
- start_i is ignored outside IDLE, with no queuing.
- Index 0 is read like any other register, with no forced zero.
- rst_i asserted in any state aborts the dump: every output returns to its reset value on the same edge and no done_o is produced. The armed flag is re-set, so a new automatic dump follows.

## Timing
- Trigger seen in cycle T: REQ in T+1, first out_valid_o in T+2.
- Each register takes 2 cycles (REQ plus SEND) when out_ready_i is held high. Each low cycle of out_ready_i adds one cycle.
- Full dump with ready held high: DONE occurs 2·NUM_REGS+1 cycles after the trigger edge (65 cycles for 32 registers).
- Automatic dump: with rst_i released before edge 1, count reaches END_COUNT at edge END_COUNT and REQ is entered at edge END_COUNT+1.
- rf_data_i is sampled only on the REQ→SEND edge. RF changes during SEND do not affect the word already captured.
- out_ready_i may be high before out_valid_o. Acceptance requires both signals high at the same edge.

## Test plan
- RF preloaded with reg[i]=i*3, out_ready_i=1, start_i pulse at cycle 5: words (0,0), (1,3) … (31,93) arrive on alternating cycles; the first valid appears at cycle 7, done_o pulses once, and freeze_o is high for exactly 65 cycles.
- No start_i, END_COUNT=15: REQ is entered at edge 16. A second dump never occurs, even after 200 further cycles.
- out_ready_i toggling pseudo-randomly: no word is dropped or duplicated, out_data_o and out_idx_o stay stable while out_valid_o&&!out_ready_i, and 32 words are received in order.
- start_i pulsed in cycles 20, 30 and 40 during a dump: exactly 32 words are produced with a single done_o.
- rst_i asserted while idx==10 is in SEND: all outputs are 0 on the next edge and done_o never rises. The automatic dump re-fires END_COUNT+1 edges after rst_i is released.
- END_COUNT=0 with start_i held low for 100 cycles: busy_o stays 0 throughout.
